// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module  : fetch_stage_if
// Purpose : Fetch-stage bundle: backend redirect, imem read port, IQ push.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_stage_if #(
  parameter int IQ_WIDTH = 64
);
  logic                redirect_valid;
  logic [31:0]         redirect_pc;
  logic [31:0]         imem_addr;
  logic [3:0]          imem_rmask;
  logic [31:0]         imem_rdata;
  logic                imem_resp;
  logic                iq_full;
  logic                iq_enqueue;
  logic [IQ_WIDTH-1:0] iq_wdata;
  logic                iq_flush;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, imem_resp, iq_full,
    output imem_addr, imem_rmask, iq_enqueue, iq_wdata, iq_flush
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, imem_resp, iq_full,
    input  imem_addr, imem_rmask, iq_enqueue, iq_wdata, iq_flush
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module  : fetch_stage
// Purpose : Single-outstanding instruction fetch feeding the instruction queue.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int          IQ_WIDTH = 64
) (
  input  wire             clk,
  input  wire             rst,
  fetch_stage_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_fetch_pc;
  logic [31:0] w_fetch_pc_next;
  logic [31:0] w_redir_pc;
  logic        w_req;
  logic        w_enq;

  assign w_redir_pc = bus.redirect_pc & ~32'h3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_fetch_pc <= w_fetch_pc_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_fetch_pc_next = r_fetch_pc;
    w_req           = 1'b0;
    w_enq           = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A stray imem_resp here is ignored; the memory contract forbids it.
        if (bus.redirect_valid) begin
          w_pc_next = w_redir_pc;
        end else if (!bus.iq_full) begin
          w_req           = 1'b1;
          w_fetch_pc_next = r_pc;
          w_state_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_resp) begin
          w_state_next = S_IDLE;
          if (bus.redirect_valid) begin
            w_pc_next = w_redir_pc;
          end else begin
            w_enq     = 1'b1;
            w_pc_next = r_pc + 32'd4;
          end
        end else if (bus.redirect_valid) begin
          w_pc_next    = w_redir_pc;
          w_state_next = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (bus.redirect_valid) w_pc_next = w_redir_pc;
        if (bus.imem_resp)      w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, even though inputs may toggle.
  assign bus.imem_rmask = (rst && w_req) ? 4'hf : 4'h0;
  assign bus.imem_addr  = (rst && w_req) ? r_pc : 32'h0;
  assign bus.iq_enqueue = rst && w_enq;
  assign bus.iq_wdata   = (rst && w_enq) ? IQ_WIDTH'({r_fetch_pc, bus.imem_rdata})
                                         : '0;
  assign bus.iq_flush   = rst && bus.redirect_valid;

  a_no_enq_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(bus.iq_enqueue && bus.iq_full));

  a_no_resp_in_idle: assert property (@(posedge clk) disable iff (!rst)
    !((r_state == S_IDLE) && bus.imem_resp));

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module  : tb_fetch_stage
// Purpose : Self-checking bench: directed vector table, corner sequences, random.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h1eceb000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_stage_if #(.IQ_WIDTH(64)) bus ();

  fetch_stage #(.RESET_PC(RPC), .IQ_WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        resp;
    logic [31:0] rdata;
    logic        full;
    logic [3:0]  e_rmask;
    logic [31:0] e_addr;
    logic        e_enq;
    logic [63:0] e_wdata;
    logic        e_flush;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [31:0] rpc, input logic resp,
                       input logic [31:0] rdata, input logic full);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.imem_resp      = resp;
    bus.imem_rdata     = rdata;
    bus.iq_full        = full;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Behavioural reference: at most one fetch in flight, possibly marked stale.
  logic [31:0] m_pc, m_fpc;
  logic        m_pend, m_stale;

  initial begin
    int enq_cnt, req_cnt, cnt;
    logic busy;
    logic [31:0] pcs [4];
    logic [31:0] data_q;

    tbl[0]  = '{0, 32'h0,        0, 32'h0,        0, 4'hf, RPC,           0, 64'h0, 0};
    tbl[1]  = '{0, 32'h0,        1, 32'h00000013, 0, 4'h0, 32'h0,         1, {RPC, 32'h00000013}, 0};
    tbl[2]  = '{0, 32'h0,        0, 32'h0,        0, 4'hf, RPC + 32'd4,   0, 64'h0, 0};
    tbl[3]  = '{1, 32'h80000002, 0, 32'h0,        0, 4'h0, 32'h0,         0, 64'h0, 1};
    tbl[4]  = '{0, 32'h0,        0, 32'h0,        0, 4'h0, 32'h0,         0, 64'h0, 0};
    tbl[5]  = '{0, 32'h0,        1, 32'hdeadbeef, 0, 4'h0, 32'h0,         0, 64'h0, 0};
    tbl[6]  = '{0, 32'h0,        0, 32'h0,        0, 4'hf, 32'h80000000,  0, 64'h0, 0};
    tbl[7]  = '{0, 32'h0,        1, 32'h00000011, 0, 4'h0, 32'h0,         1, {32'h80000000, 32'h11}, 0};
    for (int i = 8; i <= 12; i++)
      tbl[i] = '{0, 32'h0,       0, 32'h0,        1, 4'h0, 32'h0,         0, 64'h0, 0};
    tbl[13] = '{0, 32'h0,        0, 32'h0,        0, 4'hf, 32'h80000004,  0, 64'h0, 0};
    tbl[14] = '{1, 32'h00001235, 1, 32'h0000cafe, 0, 4'h0, 32'h0,         0, 64'h0, 1};
    tbl[15] = '{0, 32'h0,        0, 32'h0,        0, 4'hf, 32'h00001234,  0, 64'h0, 0};
    tbl[16] = '{0, 32'h0,        1, 32'h00000077, 0, 4'h0, 32'h0,         1, {32'h1234, 32'h77}, 0};
    tbl[17] = '{1, 32'hfffffffd, 0, 32'h0,        0, 4'h0, 32'h0,         0, 64'h0, 1};
    tbl[18] = '{0, 32'h0,        0, 32'h0,        0, 4'hf, 32'hfffffffc,  0, 64'h0, 0};
    tbl[19] = '{0, 32'h0,        1, 32'h00000001, 0, 4'h0, 32'h0,         1, {32'hfffffffc, 32'h1}, 0};
    tbl[20] = '{0, 32'h0,        0, 32'h0,        0, 4'hf, 32'h0,         0, 64'h0, 0};
    tbl[21] = '{0, 32'h0,        1, 32'h00000005, 0, 4'h0, 32'h0,         1, {32'h0, 32'h5}, 0};

    // Reset state: iq_full low would otherwise allow a request.
    drive(1'b1, 32'h1234, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("reset_rmask", {60'h0, bus.imem_rmask}, 64'h0);
    chk("reset_addr",  {32'h0, bus.imem_addr}, 64'h0);
    chk("reset_enq",   {63'h0, bus.iq_enqueue}, 64'h0);
    chk("reset_flush", {63'h0, bus.iq_flush}, 64'h0);
    chk("reset_wdata", bus.iq_wdata, 64'h0);
    do_reset();

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rv, tbl[i].rpc, tbl[i].resp, tbl[i].rdata, tbl[i].full);
      @(negedge clk);
      chk($sformatf("tbl%0d_rmask", i), {60'h0, bus.imem_rmask}, {60'h0, tbl[i].e_rmask});
      if (tbl[i].e_rmask != 4'h0)
        chk($sformatf("tbl%0d_addr", i), {32'h0, bus.imem_addr}, {32'h0, tbl[i].e_addr});
      chk($sformatf("tbl%0d_enq", i), {63'h0, bus.iq_enqueue}, {63'h0, tbl[i].e_enq});
      if (tbl[i].e_enq)
        chk($sformatf("tbl%0d_wdata", i), bus.iq_wdata, tbl[i].e_wdata);
      chk($sformatf("tbl%0d_flush", i), {63'h0, bus.iq_flush}, {63'h0, tbl[i].e_flush});
      @(posedge clk); #1;
    end

    // Four fetches through a 3-cycle memory.
    do_reset();
    enq_cnt = 0; req_cnt = 0; busy = 1'b0; cnt = 0;
    for (int c = 0; c < 60 && enq_cnt < 4; c++) begin
      logic r;
      r = 1'b0;
      if (busy) begin
        cnt--;
        r = (cnt == 0);
      end
      drive(1'b0, 32'h0, r, $urandom, 1'b0);
      @(negedge clk);
      if (r) busy = 1'b0;
      if (bus.imem_rmask == 4'hf) begin
        req_cnt++;
        busy = 1'b1;
        cnt  = 3;
      end
      if (bus.iq_enqueue) begin
        if (enq_cnt < 4) pcs[enq_cnt] = bus.iq_wdata[63:32];
        enq_cnt++;
      end
      @(posedge clk); #1;
    end
    chk("lat3_enq_count", 64'(enq_cnt), 64'd4);
    chk("lat3_req_cycles", 64'(req_cnt), 64'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("lat3_pc%0d", k), {32'h0, pcs[k]}, {32'h0, RPC + 32'(4 * k)});

    // Async reset while a request is outstanding.
    do_reset();
    @(negedge clk);
    chk("arst_first_req", {32'h0, bus.imem_addr}, {32'h0, RPC});
    @(posedge clk); #2;
    drive(1'b1, 32'h40, 1'b1, 32'h99, 1'b0);
    rst = 1'b0;
    #1;
    chk("arst_rmask", {60'h0, bus.imem_rmask}, 64'h0);
    chk("arst_enq",   {63'h0, bus.iq_enqueue}, 64'h0);
    chk("arst_flush", {63'h0, bus.iq_flush}, 64'h0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_rel_rmask", {60'h0, bus.imem_rmask}, 64'hf);
    chk("arst_rel_addr",  {32'h0, bus.imem_addr}, {32'h0, RPC});
    @(posedge clk); #1;
    @(negedge clk);
    chk("arst_no_stale_enq", {63'h0, bus.iq_enqueue}, 64'h0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 1'b1, 32'h00000013, 1'b0);
    @(negedge clk);
    chk("arst_enq_wdata", bus.iq_wdata, {RPC, 32'h00000013});
    @(posedge clk); #1;

    // Randomized traffic against the reference model.
    do_reset();
    m_pc = RPC; m_fpc = RPC; m_pend = 1'b0; m_stale = 1'b0;
    busy = 1'b0; cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      logic rv, r, full, e_req, e_enq;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 7) == 0);
      rpc = $urandom;
      r   = 1'b0;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          r    = 1'b1;
          busy = 1'b0;
        end
      end
      full   = m_pend ? 1'b0 : ($urandom_range(0, 3) == 0);
      data_q = $urandom;
      drive(rv, rpc, r, data_q, full);
      e_req = !m_pend && !rv && !full;
      e_enq = m_pend && r && !m_stale && !rv;
      @(negedge clk);
      chk("rnd_rmask", {60'h0, bus.imem_rmask}, e_req ? 64'hf : 64'h0);
      if (e_req) chk("rnd_addr", {32'h0, bus.imem_addr}, {32'h0, m_pc});
      chk("rnd_enq", {63'h0, bus.iq_enqueue}, {63'h0, e_enq});
      if (e_enq) chk("rnd_wdata", bus.iq_wdata, {m_fpc, data_q});
      chk("rnd_flush", {63'h0, bus.iq_flush}, {63'h0, rv});
      if (e_req) begin
        busy = 1'b1;
        cnt  = $urandom_range(1, 3);
      end
      if (m_pend) begin
        if (r) begin
          m_pend = 1'b0;
          if (e_enq) m_pc = m_pc + 32'd4;
        end
        if (rv) begin
          m_pc    = rpc & ~32'h3;
          m_stale = 1'b1;
        end
      end else if (rv) begin
        m_pc = rpc & ~32'h3;
      end else if (!full) begin
        m_pend  = 1'b1;
        m_stale = 1'b0;
        m_fpc   = m_pc;
      end
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
